axim_write_arbiter: RTL and testbench

//  Shares the single SDRAM AXI write port (AW/W/B, 25-bit word address, 16-bit data)

---
 rtl/axim_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axim_write_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axim_write_arbiter.sv
// axim_write_arbiter
// Shares one AXI write port (AW/W/B) between two write masters. A master owns
// the port for one complete burst (address, all data beats, response), and
// ownership alternates round-robin when both masters are waiting. A sticky
// flag reports any burst whose beat count disagrees with its awlen.

module axim_write_arbiter #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_awvalid,
   output logic              m0_awready,
   input  logic [7:0]        m0_awlen,
   input  logic [ADDR_W-1:0] m0_awaddr,
   input  logic              m0_wvalid,
   output logic              m0_wready,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_wlast,
   output logic              m0_bvalid,
   output logic              m0_bresp,
   input  logic              m0_bready,

   input  logic              m1_awvalid,
   output logic              m1_awready,
   input  logic [7:0]        m1_awlen,
   input  logic [ADDR_W-1:0] m1_awaddr,
   input  logic              m1_wvalid,
   output logic              m1_wready,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_wlast,
   output logic              m1_bvalid,
   output logic              m1_bresp,
   input  logic              m1_bready,

   output logic              s_awvalid,
   input  logic              s_awready,
   output logic [7:0]        s_awlen,
   output logic [ADDR_W-1:0] s_awaddr,
   output logic              s_wvalid,
   input  logic              s_wready,
   output logic [DATA_W-1:0] s_wdata,
   output logic              s_wlast,
   input  logic              s_bvalid,
   input  logic              s_bresp,
   output logic              s_bready,

   output logic [1:0]        grant,
   output logic              len_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       prio_q, prio_d;
   logic       lenErr_q, lenErr_d;
   logic [8:0] beatCnt_q, beatCnt_d;
   logic [8:0] expBeats_q, expBeats_d;

   logic       selM1;
   logic       inAddr, inData, inResp;
   logic [7:0] selAwlen;
   logic [8:0] beatNext;
   logic       wBeat;
   logic       pickM1;

   // The owner is a one-hot register, so bit 1 alone selects the m1 datapath.
   assign selM1    = grant_q[1];
   assign inAddr   = (state_q == ADDR);
   assign inData   = (state_q == DATA);
   assign inResp   = (state_q == RESP);
   assign selAwlen = selM1 ? m1_awlen : m0_awlen;
   assign beatNext = beatCnt_q + 9'd1;
   assign wBeat    = s_wvalid & s_wready;
   assign pickM1   = m1_awvalid & (~m0_awvalid | prio_q);

   // State, owner, priority, beat counter and error flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= 2'b00;
         prio_q     <= 1'b0;
         lenErr_q   <= 1'b0;
         beatCnt_q  <= 9'd0;
         expBeats_q <= 9'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         prio_q     <= prio_d;
         lenErr_q   <= lenErr_d;
         beatCnt_q  <= beatCnt_d;
         expBeats_q <= expBeats_d;
      end
   end

   // Burst sequencing: arbitrate, pass the address, count beats, wait for B.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      prio_d     = prio_q;
      lenErr_d   = lenErr_q;
      beatCnt_d  = beatCnt_q;
      expBeats_d = expBeats_q;
      case (state_q)
         IDLE: begin
            if (m0_awvalid | m1_awvalid) begin
               grant_d = pickM1 ? 2'b10 : 2'b01;
               state_d = ADDR;
            end
         end
         ADDR: begin
            beatCnt_d  = 9'd0;
            expBeats_d = {1'b0, selAwlen} + 9'd1;
            if (s_awvalid & s_awready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (wBeat) begin
               beatCnt_d = beatNext;
               if (s_wlast != (beatNext == expBeats_q)) begin
                  lenErr_d = 1'b1;
               end
               if (s_wlast) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (s_bvalid & s_bready) begin
               state_d = IDLE;
               grant_d = 2'b00;
               prio_d  = grant_q[0];
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   assign s_awvalid = inAddr & (selM1 ? m1_awvalid : m0_awvalid);
   assign s_awlen   = selAwlen;
   assign s_awaddr  = selM1 ? m1_awaddr : m0_awaddr;
   assign s_wvalid  = inData & (selM1 ? m1_wvalid : m0_wvalid);
   assign s_wdata   = selM1 ? m1_wdata : m0_wdata;
   assign s_wlast   = inData & (selM1 ? m1_wlast : m0_wlast);
   assign s_bready  = inResp & (selM1 ? m1_bready : m0_bready);

   assign m0_awready = inAddr & grant_q[0] & s_awready;
   assign m1_awready = inAddr & grant_q[1] & s_awready;
   assign m0_wready  = inData & grant_q[0] & s_wready;
   assign m1_wready  = inData & grant_q[1] & s_wready;
   assign m0_bvalid  = inResp & grant_q[0] & s_bvalid;
   assign m1_bvalid  = inResp & grant_q[1] & s_bvalid;
   assign m0_bresp   = inResp & grant_q[0] & s_bresp;
   assign m1_bresp   = inResp & grant_q[1] & s_bresp;

   assign grant   = grant_q;
   assign len_err = lenErr_q;

endmodule

// File: tb/tb_axim_write_arbiter.sv
// Bench for axim_write_arbiter: master drivers push expected AW/W traffic into
// per-master queues, a slave-side monitor pops and compares it, and a table of
// single-burst vectors plus hand-written sequences covers arbitration corners.

module tb_axim_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast;
   logic        m0_bvalid, m0_bresp, m0_bready;
   logic [7:0]  m0_awlen;
   logic [24:0] m0_awaddr;
   logic [15:0] m0_wdata;
   logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast;
   logic        m1_bvalid, m1_bresp, m1_bready;
   logic [7:0]  m1_awlen;
   logic [24:0] m1_awaddr;
   logic [15:0] m1_wdata;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
   logic        s_bvalid, s_bresp, s_bready;
   logic [7:0]  s_awlen;
   logic [24:0] s_awaddr;
   logic [15:0] s_wdata;
   logic [1:0]  grant;
   logic        len_err;

   typedef struct {
      int          m;
      logic [24:0] addr;
      int          len;
      int          lastBeat;
      int          awStall;
      bit          wToggle;
      bit          bresp;
      bit          expErr;
   } vec_t;

   vec_t        vecs[6];
   int          checks = 0;
   int          failures = 0;
   int          awStall = 0;
   bit          wToggle = 1'b0;
   logic        brespCfg = 1'b0;
   logic [32:0] awQ0[$];
   logic [32:0] awQ1[$];
   logic [16:0] wQ0[$];
   logic [16:0] wQ1[$];
   int          grantLog[$];

   axim_write_arbiter #(.ADDR_W(25), .DATA_W(16)) dut (
      .clk(clk), .reset(reset),
      .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awlen(m0_awlen),
      .m0_awaddr(m0_awaddr), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_wdata(m0_wdata), .m0_wlast(m0_wlast), .m0_bvalid(m0_bvalid),
      .m0_bresp(m0_bresp), .m0_bready(m0_bready),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awlen(m1_awlen),
      .m1_awaddr(m1_awaddr), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_wdata(m1_wdata), .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid),
      .m1_bresp(m1_bresp), .m1_bready(m1_bready),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awlen(s_awlen),
      .s_awaddr(s_awaddr), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_wdata(s_wdata), .s_wlast(s_wlast), .s_bvalid(s_bvalid),
      .s_bresp(s_bresp), .s_bready(s_bready),
      .grant(grant), .len_err(len_err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic setAw(input int m, input logic v, input logic [24:0] a, input logic [7:0] l);
      if (m == 0) begin
         m0_awvalid = v; m0_awaddr = a; m0_awlen = l;
      end else begin
         m1_awvalid = v; m1_awaddr = a; m1_awlen = l;
      end
   endtask

   task automatic setW(input int m, input logic v, input logic [15:0] d, input logic last);
      if (m == 0) begin
         m0_wvalid = v; m0_wdata = d; m0_wlast = last;
      end else begin
         m1_wvalid = v; m1_wdata = d; m1_wlast = last;
      end
   endtask

   task automatic setB(input int m, input logic v);
      if (m == 0) m0_bready = v;
      else m1_bready = v;
   endtask

   function automatic logic getAwready(input int m);
      return (m == 0) ? m0_awready : m1_awready;
   endfunction

   function automatic logic getWready(input int m);
      return (m == 0) ? m0_wready : m1_wready;
   endfunction

   function automatic logic getBvalid(input int m);
      return (m == 0) ? m0_bvalid : m1_bvalid;
   endfunction

   function automatic logic getBresp(input int m);
      return (m == 0) ? m0_bresp : m1_bresp;
   endfunction

   task automatic clearQueues();
      awQ0.delete(); awQ1.delete(); wQ0.delete(); wQ1.delete();
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      reset = 1'b1;
      setAw(0, 1'b0, 25'd0, 8'd0); setAw(1, 1'b0, 25'd0, 8'd0);
      setW(0, 1'b0, 16'd0, 1'b0);  setW(1, 1'b0, 16'd0, 1'b0);
      setB(0, 1'b0); setB(1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      clearQueues();
      reset = 1'b0;
   endtask

   // Slave model: stalls AW for awStall cycles, optionally toggles wready,
   // and answers each completed burst with one B response.
   logic slvHsW, slvHsB;
   int   awWait = 0;
   initial begin
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 1'b0;
      forever begin
         @(negedge clk);
         slvHsW = s_wvalid & s_wready & s_wlast;
         slvHsB = s_bvalid & s_bready;
         @(posedge clk);
         #2;
         if (reset) begin
            s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 1'b0;
            awWait = 0;
         end else begin
            s_awready = s_awvalid && (awWait >= awStall);
            awWait = s_awvalid ? awWait + 1 : 0;
            s_wready = wToggle ? ~s_wready : 1'b1;
            if (slvHsB) s_bvalid = 1'b0;
            if (slvHsW) begin
               s_bvalid = 1'b1;
               s_bresp  = brespCfg;
            end
         end
      end
   end

   // Slave-side scoreboard: AW and W traffic compared against what the drivers queued.
   int          monG;
   int          monQn;
   logic [32:0] awExp;
   logic [16:0] wExp;
   always @(negedge clk) begin
      monG = grant[1] ? 1 : 0;
      if (s_awvalid) begin
         checkOutput("aw_grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 32'd1);
         monQn = (monG == 0) ? awQ0.size() : awQ1.size();
         checkOutput("aw_expected_pending", 32'(monQn > 0), 32'd1);
         if (monQn > 0) begin
            awExp = (monG == 0) ? awQ0[0] : awQ1[0];
            checkOutput("aw_addr", 32'(s_awaddr), 32'(awExp[32:8]));
            checkOutput("aw_len", 32'(s_awlen), 32'(awExp[7:0]));
            if (s_awready) begin
               if (monG == 0) void'(awQ0.pop_front());
               else void'(awQ1.pop_front());
               grantLog.push_back(monG);
               checkOutput("aw_other_ready", 32'((monG == 0) ? m1_awready : m0_awready), 32'd0);
            end
         end
      end
      if (s_wvalid && s_wready) begin
         monQn = (monG == 0) ? wQ0.size() : wQ1.size();
         checkOutput("w_expected_pending", 32'(monQn > 0), 32'd1);
         if (monQn > 0) begin
            wExp = (monG == 0) ? wQ0.pop_front() : wQ1.pop_front();
            checkOutput("w_data", 32'(s_wdata), 32'(wExp[16:1]));
            checkOutput("w_last", 32'(s_wlast), 32'(wExp[0]));
            checkOutput("w_other_ready",
                        32'((monG == 0) ? (m1_wready | m1_awready) : (m0_wready | m0_awready)), 32'd0);
         end
      end
   end

   // One master burst: AW, lastBeat data beats, then B. abortBeat>0 asserts
   // reset while that beat is presented and leaves the burst unfinished.
   task automatic applyStimulus(input int m, input logic [24:0] addr, input int len,
                                input int lastBeat, input int base, input logic expBresp,
                                input bit fromIdle, input int abortBeat);
      bit          seen;
      logic [7:0]  l8;
      logic [15:0] d;
      l8 = len[7:0];
      @(posedge clk); #1;
      if (m == 0) awQ0.push_back({addr, l8});
      else awQ1.push_back({addr, l8});
      setAw(m, 1'b1, addr, l8);
      @(negedge clk);
      if (fromIdle) begin
         checkOutput("aw_latency_grant", 32'(grant), 32'd0);
         checkOutput("aw_latency_valid", 32'(s_awvalid), 32'd0);
      end
      seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         if (getAwready(m)) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("aw_handshake", 32'(seen), 32'd1);
      @(posedge clk); #1;
      setAw(m, 1'b0, 25'd0, 8'd0);
      for (int i = 1; i <= lastBeat; i++) begin
         d = 16'(base + i - 1);
         if (m == 0) wQ0.push_back({d, 1'b0 | (i == lastBeat)});
         else wQ1.push_back({d, 1'b0 | (i == lastBeat)});
         setW(m, 1'b1, d, i == lastBeat);
         if (i == abortBeat) begin
            reset = 1'b1;
            @(posedge clk); #1;
            checkOutput("rst_grant", 32'(grant), 32'd0);
            checkOutput("rst_s_wvalid", 32'(s_wvalid), 32'd0);
            checkOutput("rst_m_wready", 32'(getWready(m)), 32'd0);
            checkOutput("rst_s_bready", 32'(s_bready), 32'd0);
            setW(m, 1'b0, 16'd0, 1'b0);
            clearQueues();
            return;
         end
         seen = 1'b0;
         for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (getWready(m)) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) begin
            checkOutput("w_handshake", 32'(seen), 32'd1);
            break;
         end
         @(posedge clk); #1;
      end
      setW(m, 1'b0, 16'd0, 1'b0);
      setB(m, 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (getBvalid(m)) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("b_handshake", 32'(seen), 32'd1);
      checkOutput("b_resp", 32'(getBresp(m)), 32'(expBresp));
      checkOutput("b_other_valid", 32'(getBvalid(1 - m)), 32'd0);
      @(posedge clk); #1;
      setB(m, 1'b0);
      @(negedge clk);
      checkOutput("b_one_cycle", 32'(getBvalid(m)), 32'd0);
      checkOutput("idle_grant", 32'(grant), 32'd0);
   endtask

   task automatic checkGrantOrder(input string name, input int first, input int second);
      checkOutput({name, "_count"}, 32'(grantLog.size()), 32'd2);
      if (grantLog.size() == 2) begin
         checkOutput({name, "_first"}, 32'(grantLog[0]), 32'(first));
         checkOutput({name, "_second"}, 32'(grantLog[1]), 32'(second));
      end
   endtask

   // Bound on total run time in case the DUT never answers.
   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Main sequence: reset state, vector table, then multi-cycle corner cases.
   initial begin
      reset = 1'b1;
      setAw(0, 1'b0, 25'd0, 8'd0); setAw(1, 1'b0, 25'd0, 8'd0);
      setW(0, 1'b0, 16'd0, 1'b0);  setW(1, 1'b0, 16'd0, 1'b0);
      setB(0, 1'b0); setB(1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_grant", 32'(grant), 32'd0);
      checkOutput("reset_len_err", 32'(len_err), 32'd0);
      checkOutput("reset_valids", 32'({s_awvalid, s_wvalid, s_bready, m0_bvalid, m1_bvalid}), 32'd0);
      checkOutput("reset_readys", 32'({m0_awready, m1_awready, m0_wready, m1_wready}), 32'd0);

      vecs[0] = '{m: 0, addr: 25'h0000000, len: 31, lastBeat: 32, awStall: 0, wToggle: 0, bresp: 0, expErr: 0};
      vecs[1] = '{m: 1, addr: 25'h1ABCDEF, len: 7,  lastBeat: 8,  awStall: 5, wToggle: 1, bresp: 0, expErr: 0};
      vecs[2] = '{m: 0, addr: 25'h0000100, len: 0,  lastBeat: 1,  awStall: 0, wToggle: 1, bresp: 0, expErr: 0};
      vecs[3] = '{m: 1, addr: 25'h0123456, len: 15, lastBeat: 16, awStall: 2, wToggle: 0, bresp: 1, expErr: 0};
      vecs[4] = '{m: 1, addr: 25'h0000040, len: 3,  lastBeat: 2,  awStall: 0, wToggle: 0, bresp: 0, expErr: 1};
      vecs[5] = '{m: 0, addr: 25'h1FFFFFF, len: 4,  lastBeat: 5,  awStall: 1, wToggle: 1, bresp: 0, expErr: 1};

      for (int k = 0; k < 6; k++) begin
         awStall  = vecs[k].awStall;
         wToggle  = vecs[k].wToggle;
         brespCfg = vecs[k].bresp;
         grantLog.delete();
         applyStimulus(vecs[k].m, vecs[k].addr, vecs[k].len, vecs[k].lastBeat,
                       100 + k * 300, vecs[k].bresp, 1'b1, 0);
         checkOutput("vec_grant_logged", 32'(grantLog.size()), 32'd1);
         if (grantLog.size() == 1) checkOutput("vec_grant_owner", 32'(grantLog[0]), 32'(vecs[k].m));
         checkOutput("vec_len_err", 32'(len_err), 32'(vecs[k].expErr));
      end

      // Beat awlen+1 arrives without wlast; burst still ends on the later wlast.
      doReset();
      awStall = 0; wToggle = 1'b0; brespCfg = 1'b0;
      checkOutput("rst_clears_len_err", 32'(len_err), 32'd0);
      applyStimulus(0, 25'h10, 1, 3, 5000, 1'b0, 1'b1, 0);
      checkOutput("missing_wlast_len_err", 32'(len_err), 32'd1);

      // Simultaneous requests after reset: m0 first, then m1.
      doReset();
      grantLog.delete();
      fork
         applyStimulus(0, 25'h200, 3, 4, 6000, 1'b0, 1'b1, 0);
         applyStimulus(1, 25'h300, 2, 3, 7000, 1'b0, 1'b1, 0);
      join
      checkGrantOrder("rr_after_reset", 0, 1);
      // A lone m0 burst hands priority to m1, so the next collision favours m1.
      applyStimulus(0, 25'h400, 0, 1, 8000, 1'b0, 1'b1, 0);
      grantLog.delete();
      fork
         applyStimulus(0, 25'h500, 1, 2, 9000, 1'b0, 1'b1, 0);
         applyStimulus(1, 25'h600, 1, 2, 9500, 1'b0, 1'b1, 0);
      join
      checkGrantOrder("rr_after_m0", 1, 0);
      checkOutput("rr_len_err", 32'(len_err), 32'd0);

      // Reset on beat 10 of a 32-beat burst, then a fresh m1 burst.
      doReset();
      applyStimulus(0, 25'h55, 31, 32, 200, 1'b0, 1'b1, 10);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("abort_len_err", 32'(len_err), 32'd0);
      grantLog.delete();
      applyStimulus(1, 25'h77, 5, 6, 300, 1'b0, 1'b1, 0);
      checkOutput("post_abort_logged", 32'(grantLog.size()), 32'd1);
      if (grantLog.size() == 1) checkOutput("post_abort_owner", 32'(grantLog[0]), 32'd1);
      checkOutput("post_abort_len_err", 32'(len_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
